// File: rtl/video_scanout_if.sv
// Pixel stream handshake between pixel_generator (master) and video_scanout (slave).
// A transfer happens on any rising clock edge where pixel_valid && pixel_ready.
interface video_scanout_if;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;

  modport master (
    output pixel_data,
    output pixel_valid,
    input  pixel_ready
  );

  modport slave (
    input  pixel_data,
    input  pixel_valid,
    output pixel_ready
  );
endinterface

// File: rtl/video_scanout.sv
// Raster scanout with a 2-deep pixel FIFO, registered sync/DE/RGB and a per-frame restart pulse.
// Optional sticky underflow output enabled by defining VIDEO_SCANOUT_UNDERFLOW_FLAG_EN.
module video_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                  in_clk,
  input  logic                  in_reset_n,
  video_scanout_if.slave        pix,
  output logic                  out_next_frame,
  output logic [23:0]           out_rgb,
  output logic                  out_de,
  output logic                  out_hsync,
  output logic                  out_vsync
`ifdef VIDEO_SCANOUT_UNDERFLOW_FLAG_EN
  ,
  output logic                  out_underflow
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  // One extra bit on the thresholds so a region end equal to the total never wraps.
  localparam int HX      = HW + 1;
  localparam int VX      = VW + 1;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HX-1:0] H_ACT_X    = HX'(H_ACTIVE);
  localparam logic [HX-1:0] HS_START_X = HX'(H_ACTIVE + H_FRONT);
  localparam logic [HX-1:0] HS_END_X   = HX'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VX-1:0] V_ACT_X    = VX'(V_ACTIVE);
  localparam logic [VX-1:0] VS_START_X = VX'(V_ACTIVE + V_FRONT);
  localparam logic [VX-1:0] VS_END_X   = VX'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [HX-1:0] h_x;
  logic [VX-1:0] v_x;

  logic [23:0] mem0, mem1, mem0_nxt, mem1_nxt;
  logic [1:0]  count, count_nxt;

  logic active, flush, hs_on, vs_on;
  logic full, empty, ready, push, pop;

  assign h_x = {1'b0, h};
  assign v_x = {1'b0, v};

  always_comb begin
    active = (h_x < H_ACT_X) && (v_x < V_ACT_X);
    flush  = (h == '0) && (v_x == V_ACT_X);
    hs_on  = (h_x >= HS_START_X) && (h_x < HS_END_X);
    vs_on  = (v_x >= VS_START_X) && (v_x < VS_END_X);
    full   = (count == 2'd2);
    empty  = (count == 2'd0);
    // Gated by reset so the producer never sees ready while the block is held.
    ready  = in_reset_n && !full && !flush;
    push   = pix.pixel_valid && ready;
    pop    = active && !empty;
  end

  assign pix.pixel_ready = ready;

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // Flush wins over everything; a push alongside a pop can only happen with one entry held.
  always_comb begin
    count_nxt = count;
    mem0_nxt  = mem0;
    mem1_nxt  = mem1;
    if (flush) begin
      count_nxt = 2'd0;
    end else if (pop && push) begin
      mem0_nxt = pix.pixel_data;
    end else if (pop) begin
      mem0_nxt  = mem1;
      count_nxt = count - 2'd1;
    end else if (push) begin
      if (empty) begin
        mem0_nxt = pix.pixel_data;
      end else begin
        mem1_nxt = pix.pixel_data;
      end
      count_nxt = count + 2'd1;
    end
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      count <= 2'd0;
      mem0  <= '0;
      mem1  <= '0;
    end else begin
      count <= count_nxt;
      mem0  <= mem0_nxt;
      mem1  <= mem1_nxt;
    end
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      out_next_frame <= 1'b0;
      out_rgb        <= '0;
      out_de         <= 1'b0;
      out_hsync      <= ~SYNC_POL;
      out_vsync      <= ~SYNC_POL;
    end else begin
      out_next_frame <= flush;
      out_rgb        <= pop ? mem0 : 24'h000000;
      out_de         <= active;
      out_hsync      <= hs_on ? SYNC_POL : ~SYNC_POL;
      out_vsync      <= vs_on ? SYNC_POL : ~SYNC_POL;
    end
  end

`ifdef VIDEO_SCANOUT_UNDERFLOW_FLAG_EN
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      out_underflow <= 1'b0;
    end else if (active && empty) begin
      out_underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_video_scanout.sv
// Self-checking bench for video_scanout on a tiny 8x6 raster (48 cycles per frame).
// Expected outputs come from a queue-based model driven by the raster position of each cycle.
module tb_video_scanout;

  localparam int H_ACTIVE = 4, H_FRONT = 1, H_SYNC = 2, H_BACK = 1;
  localparam int V_ACTIVE = 3, V_FRONT = 1, V_SYNC = 1, V_BACK = 1;
  localparam bit SYNC_POL = 1'b0;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic        clk;
  logic        reset_n;
  logic        next_frame;
  logic [23:0] rgb;
  logic        de;
  logic        hsync;
  logic        vsync;
`ifdef VIDEO_SCANOUT_UNDERFLOW_FLAG_EN
  logic        underflow;
`endif

  video_scanout_if pix ();

  video_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .SYNC_POL(SYNC_POL)
  ) dut (
    .in_clk(clk),
    .in_reset_n(reset_n),
    .pix(pix),
    .out_next_frame(next_frame),
    .out_rgb(rgb),
    .out_de(de),
    .out_hsync(hsync),
    .out_vsync(vsync)
`ifdef VIDEO_SCANOUT_UNDERFLOW_FLAG_EN
    ,
    .out_underflow(underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  int          n;
  int          pulses;
  logic [23:0] next_data;
  logic [23:0] q[$];
  bit          model_uf;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, n);
    end
  endtask

  task automatic applyStimulus(input bit valid);
    pix.pixel_valid = valid;
    pix.pixel_data  = next_data;
  endtask

  task automatic resetModel();
    n        = 0;
    model_uf = 1'b0;
    q.delete();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, pix.pixel_ready, 1'b0);
    checkOutput({tag, "_next_frame"}, next_frame, 1'b0);
    checkOutput({tag, "_rgb"}, rgb, 24'h0);
    checkOutput({tag, "_de"}, de, 1'b0);
    checkOutput({tag, "_hsync"}, hsync, !SYNC_POL);
    checkOutput({tag, "_vsync"}, vsync, !SYNC_POL);
`ifdef VIDEO_SCANOUT_UNDERFLOW_FLAG_EN
    checkOutput({tag, "_underflow"}, underflow, 1'b0);
`endif
  endtask

  // One raster cycle: drive at the falling edge, check ready, then check registered outputs after the rise.
  task automatic runCycle(input bit valid);
    int          p, h, v;
    bit          act, flush, exp_ready, push, taken;
    logic [23:0] exp_rgb;
    @(negedge clk);
    applyStimulus(valid);
    p         = n % FRAME;
    h         = p % H_TOTAL;
    v         = p / H_TOTAL;
    act       = (h < H_ACTIVE) && (v < V_ACTIVE);
    flush     = (h == 0) && (v == V_ACTIVE);
    exp_ready = (q.size() < 2) && !flush;
    #1;
    checkOutput("ready", pix.pixel_ready, exp_ready);
    taken   = valid && (pix.pixel_ready === 1'b1);
    push    = valid && exp_ready;
    exp_rgb = (act && q.size() > 0) ? q[0] : 24'h0;
    if (act && q.size() == 0) model_uf = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("de", de, act);
    checkOutput("rgb", rgb, exp_rgb);
    checkOutput("hsync", hsync,
                (h >= H_ACTIVE + H_FRONT && h < H_ACTIVE + H_FRONT + H_SYNC) ? SYNC_POL : !SYNC_POL);
    checkOutput("vsync", vsync,
                (v >= V_ACTIVE + V_FRONT && v < V_ACTIVE + V_FRONT + V_SYNC) ? SYNC_POL : !SYNC_POL);
    checkOutput("next_frame", next_frame, flush);
`ifdef VIDEO_SCANOUT_UNDERFLOW_FLAG_EN
    checkOutput("underflow", underflow, model_uf);
`endif
    if (next_frame === 1'b1) pulses++;
    if (flush) begin
      q.delete();
    end else begin
      if (act && q.size() > 0) void'(q.pop_front());
      if (push) q.push_back(next_data);
    end
    if (taken) next_data = next_data + 24'd1;
    n++;
  endtask

  task automatic runToFrameStart();
    while (n % FRAME != 0) runCycle(1'b1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    pulses    = 0;
    next_data = 24'd1;
    reset_n   = 1'b0;
    pix.pixel_valid = 1'b0;
    pix.pixel_data  = 24'h0;
    resetModel();

    repeat (3) @(posedge clk);
    #2;
    checkResetValues("held");
    $display("[TB] releasing reset");
    @(posedge clk);
    #3 reset_n = 1'b1;

    // Continuous stream; the very first active pixel underflows.
    for (int i = 0; i < 2 * FRAME; i++) runCycle(1'b1);

    // Exactly one restart pulse per frame.
    pulses = 0;
    for (int i = 0; i < FRAME; i++) runCycle(1'b1);
    checkOutput("frame_pulses", pulses, 1);

    // Random valid everywhere.
    for (int i = 0; i < 2 * FRAME; i++) runCycle(1'($urandom_range(0, 1)));

    // Random valid during active lines only, idle during blanking.
    runToFrameStart();
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((i % H_TOTAL) < H_ACTIVE && (i / H_TOTAL) % V_TOTAL < V_ACTIVE)
        runCycle(1'($urandom_range(0, 1)));
      else
        runCycle(1'b0);
    end

    // Starve line 0, then resume.
    runToFrameStart();
    for (int i = 0; i < H_TOTAL; i++) runCycle(1'b0);
    for (int i = H_TOTAL; i < 2 * FRAME; i++) runCycle(1'b1);

    // Reset asserted mid-line at h=2, v=1.
    runToFrameStart();
    while (n % FRAME != H_TOTAL + 2) runCycle(1'b1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkResetValues("midreset");
    @(posedge clk);
    #3 reset_n = 1'b1;
    resetModel();

    for (int i = 0; i < 2 * FRAME; i++) runCycle(1'($urandom_range(0, 3) != 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_scanout.md
# video_scanout

Stream consumer for the pixel path. Accepts 24-bit RGB pixels over the valid/ready handshake driven by `pixel_generator` and emits them on a raster with generated hsync/vsync/data-enable. Buffers two pixels ahead of the raster and pulses `out_next_frame` at the start of vertical blanking so the generator can restart its frame. Sits between `pixel_generator` and the display PHY/DAC.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch, cycles
- `H_SYNC`, 96, hsync width, cycles
- `H_BACK`, 48, horizontal back porch, cycles
- `V_ACTIVE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch, lines
- `V_SYNC`, 2, vsync width, lines
- `V_BACK`, 33, vertical back porch, lines
- `SYNC_POL`, 0, sync active level (0 = active-low)

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `in_clk` input 1: pixel clock; all state on rising edge
- `in_reset_n` input 1: asynchronous active-low reset
- `in_pixel_data` input 24: RGB {R[23:16],G[15:8],B[7:0]}
- `in_pixel_valid` input 1: pixel present
- `in_pixel_ready` output 1: block accepts pixel this cycle
- `out_next_frame` output 1: one-cycle frame-restart pulse, wired to generator `in_next_frame`
- `out_rgb` output 24: displayed pixel, 0 outside active region
- `out_de` output 1: data enable, high in active region
- `out_hsync` output 1: horizontal sync
- `out_vsync` output 1: vertical sync
- `out_underflow` output 1: sticky underflow flag (only with macro, see Configuration)

## Operation
- Counters `h` in [0, H_TOTAL-1], `v` in [0, V_TOTAL-1]; H_TOTAL = sum of H params, V_TOTAL = sum of V params. Widths `$clog2` of totals. `h` wraps to 0 at H_TOTAL-1 and increments `v`; `v` wraps to 0 at V_TOTAL-1.
- Region order per axis: active, front porch, sync, back porch. Active = `h < H_ACTIVE && v < V_ACTIVE`.
- 2-entry FIFO. Handshake: transfer when `in_pixel_valid && in_pixel_ready`. `in_pixel_ready` = FIFO not full and not flush cycle. Data held by producer until transfer; block never depends on valid for ready.
- Active cycle: pop one entry. FIFO empty in active cycle = underflow: display 24'h000000, nothing popped, set sticky flag.
- Simultaneous push and pop on full FIFO: ready is low (full), so no push; pop only. On 1-entry FIFO: push and pop both occur, count unchanged.
- Flush: cycle with `h == 0 && v == V_ACTIVE` asserts `out_next_frame`, clears FIFO, forces ready low that cycle. Stale pixels from an underflowed/overrun frame are discarded.
- Blanking cycles: no pop; FIFO fills to 2 and holds.

## Timing
- Reset values: `h=0`, `v=0`, FIFO empty, `in_pixel_ready=0`, `out_next_frame=0`, `out_rgb=0`, `out_de=0`, `out_hsync=out_vsync=!SYNC_POL` (inactive), `out_underflow=0`.
- First cycle after reset release: ready = 1 (FIFO empty). Raster starts at (0,0) immediately; if no pixel yet, underflow.
- Outputs registered: `out_rgb/out_de/out_hsync/out_vsync` reflect counter position of previous cycle (latency 1). Pixel accepted at cycle t can appear no earlier than t+1.
- `out_next_frame` registered alongside: high exactly one cycle per frame, cycle after counter reaches (0, V_ACTIVE).
- hsync active for `H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC`; vsync active for whole lines `V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC`.
- Reset mid-frame: all state returns to reset values asynchronously; FIFO contents lost.

## Configuration
- `VIDEO_SCANOUT_UNDERFLOW_FLAG_EN` defined: `out_underflow` port present; set on any underflow cycle, cleared only by reset.
- Not defined: port and flag logic absent; underflow still outputs black and pops nothing.

## Test plan
(Bench params: H_ACTIVE=4, H_FRONT=1, H_SYNC=2, H_BACK=1, V_ACTIVE=3, V_FRONT=1, V_SYNC=1, V_BACK=1, SYNC_POL=0.)
- Reset held, then released -> all outputs at reset values; ready=1 first cycle after release; hsync low cycles h=5..6, vsync low for line v=4.
- Valid held high, incrementing data 1,2,3,... -> after first frame `out_rgb` in active shows consecutive values, `out_de` high 4 cycles/line, 12 pixels/frame.
- Ready toggling source with valid low during blanking -> FIFO fills to 2, ready drops to 0, no data lost or duplicated.
- Valid held low through line 0 -> `out_rgb`=0 in active, `out_underflow`=1 (macro on) and stays 1 after valid resumes.
- Frame boundary -> `out_next_frame` high exactly once per 48 cycles, at cycle after (h=0,v=3); FIFO holding 2 pixels is emptied, ready low that cycle.
- Reset asserted mid-line (h=2, v=1) -> outputs immediately at reset values; after release raster restarts at (0,0).
